// File: rtl/aes_cipher.sv
// aes_cipher: iterative AES-128/192/256 forward cipher, one round per clock.
// Define AES_CIPHER_RESTART_EN to let a cs rising edge abort and restart a running block.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   assign y = TABLE[11'd2047 - {a, 3'd0} -: 8];
endmodule

module aes_cipher (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic [3:0]    Nr,
   input  logic [127:0]  init,
   input  logic [1919:0] w,
   output logic [127:0]  Encrypted_Msg,
   output logic          flag
);
   logic [127:0] state, sub, shifted, mixed, rkey;
   logic [3:0]   round, nr_q;
   logic         busy, cs_q, start, go;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   assign start = cs & ~cs_q;
`ifdef AES_CIPHER_RESTART_EN
   assign go = start;
`else
   assign go = start & ~busy;
`endif
   assign rkey = w[11'd1919 - {round, 7'd0} -: 128];

   // byte i is s[i%4, i/4]; ShiftRows pulls row r from column (c+r)%4
   for (genvar i = 0; i < 16; i++) begin : g_byte
      aes_sbox u_sbox (.a(state[127-8*i -: 8]), .y(sub[127-8*i -: 8]));
      assign shifted[127-8*i -: 8] = sub[127-8*((((i/4)+(i%4))%4)*4 + (i%4)) -: 8];
   end
   for (genvar c = 0; c < 4; c++) begin : g_col
      assign mixed[127-32*c -: 32] = mix_col(shifted[127-32*c -: 32]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= '0;
         round         <= '0;
         nr_q          <= '0;
         busy          <= 1'b0;
         cs_q          <= 1'b0;
         Encrypted_Msg <= '0;
         flag          <= 1'b0;
      end else begin
         cs_q <= cs;
         if (go) begin
            state <= init ^ w[1919 -: 128];
            round <= 4'd1;
            nr_q  <= (Nr == 4'd12 || Nr == 4'd14) ? Nr : 4'd10;
            busy  <= 1'b1;
            flag  <= 1'b0;
         end else if (busy) begin
            if (round == nr_q) begin
               Encrypted_Msg <= shifted ^ rkey;
               flag          <= 1'b1;
               busy          <= 1'b0;
            end else begin
               state <= mixed ^ rkey;
               round <= round + 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_aes_cipher.sv
// tb_aes_cipher: FIPS-197 vectors plus random blocks against a table-free AES model.
module tb_aes_cipher;
   logic          clk = 1'b0, rst = 1'b1, cs = 1'b0;
   logic [3:0]    nr = 4'd10;
   logic [127:0]  init = '0, msg;
   logic [1919:0] w = '0;
   logic          flag;
   logic [7:0]    sb [256];
   int            n_checks = 0, n_pass = 0;

   aes_cipher dut (.clk(clk), .rst(rst), .cs(cs), .Nr(nr), .init(init), .w(w),
                   .Encrypted_Msg(msg), .flag(flag));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256 && x != 0; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
      logic [31:0]   wd [60];
      logic [31:0]   t;
      logic [7:0]    rc = 8'h01;
      logic [1919:0] r = '0;
      int            total = 4 * (nk + 7);
      for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
      for (int i = nk; i < total; i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) t = subw(t);
         wd[i] = wd[i-nk] ^ t;
      end
      for (int i = 0; i < total; i++) r[1919-32*i -: 32] = wd[i];
      return r;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ks, input int rounds);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] out;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ ks[1919-8*(4*c+r) -: 8];
      for (int rd = 1; rd <= rounds; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[r][c] = (rd == rounds) ? t[r][c] :
                  gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] ^= ks[1919-128*rd-8*(4*c+r) -: 8];
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) out[127-8*(4*c+r) -: 8] = s[r][c];
      return out;
   endfunction

   task automatic wait_flag(output int k);
      k = -1;
      for (int e = 1; e <= 40 && k < 0; e++) begin
         @(posedge clk);
         #1;
         if (flag) k = e;
      end
   endtask

   task automatic run(input string tag, input logic [255:0] key, input int nk, input logic [127:0] pt,
                      input logic [3:0] nr_in, input logic [127:0] exp, input int lat);
      int k;
      @(negedge clk);
      cs = 1'b0; w = expand(key, nk); init = pt; nr = nr_in;
      @(negedge clk);
      cs = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " flag at start"}, 128'(flag), 128'd0);
      wait_flag(k);
      check({tag, " latency"}, 128'(k), 128'(lat));
      check({tag, " ciphertext"}, msg, exp);
   endtask

   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   initial begin
      int k, drops;
      logic [127:0] pt2, held;
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      check("reset flag", 128'(flag), 128'd0);
      check("reset msg", msg, 128'd0);
      @(negedge clk);
      rst = 1'b0;

      run("fips_b", KEY_B, 4, PT_B, 4'd10, CT_B, 10);
      run("fips_c1", {KEY_C[255:128], 128'h0}, 4, PT_C, 4'd10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 10);
      run("fips_c2", {KEY_C[255:64], 64'h0}, 6, PT_C, 4'd12, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 12);
      run("fips_c3", KEY_C, 8, PT_C, 4'd14, 128'h8ea2b7ca516745bfeafc49904b496089, 14);

      for (int it = 0; it < 10; it++) begin
         logic [255:0] key;
         logic [127:0] pt;
         logic [3:0]   nr_in;
         int           eff, sel;
         key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         pt = {$urandom(), $urandom(), $urandom(), $urandom()};
         sel = $urandom_range(0, 3);
         nr_in = (sel == 0) ? 4'd10 : (sel == 1) ? 4'd12 : (sel == 2) ? 4'd14 : 4'($urandom_range(0, 15));
         eff = (nr_in == 4'd12 || nr_in == 4'd14) ? int'(nr_in) : 10;
         run($sformatf("rand%0d nr%0d", it, nr_in), key, eff - 6, pt, nr_in,
             encrypt(pt, expand(key, eff - 6), eff), eff);
      end

      // reset at round 5, then cs held high through reset release
      @(negedge clk);
      cs = 1'b0; w = expand({KEY_C[255:128], 128'h0}, 4); init = PT_C; nr = 4'd10;
      @(negedge clk);
      cs = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrun reset flag", 128'(flag), 128'd0);
      check("midrun reset msg", msg, 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      wait_flag(k);
      check("post-reset latency", 128'(k), 128'd10);
      check("post-reset ciphertext", msg, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      held = msg;
      drops = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (!flag) drops++;
      end
      check("cs held no rerun", 128'(drops), 128'd0);
      check("cs held msg stable", msg, held);

      // cs low->high at round 3 with a new plaintext
      @(negedge clk);
      cs = 1'b0; w = expand(KEY_B, 4); init = PT_B; nr = 4'd10;
      @(negedge clk);
      cs = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cs = 1'b0;
      @(posedge clk);
      @(negedge clk);
      pt2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      cs = 1'b1; init = pt2;
      @(posedge clk);
      #1;
      check("toggle flag low", 128'(flag), 128'd0);
      wait_flag(k);
`ifdef AES_CIPHER_RESTART_EN
      check("restart latency", 128'(k), 128'd10);
      check("restart ciphertext", msg, encrypt(pt2, w, 10));
`else
      check("ignored toggle latency", 128'(k), 128'd6);
      check("ignored toggle ciphertext", msg, CT_B);
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/aes_cipher.md
# aes_cipher

Iterative AES forward-cipher engine supporting AES-128/192/256 (FIPS-197). It takes a 128-bit plaintext block and a pre-expanded key schedule, computes one round per clock, and presents the ciphertext with a completion flag. It sits between the key-expansion block, which supplies the schedule, and the SPI subordinate, which returns the ciphertext to the host.

## Interface
Parameters:
- None. Key size is selected at run time through `Nr`.

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Reset. Synchronous, active-high.
- `cs`  in  1  Start request. Its rising edge, as sampled on `clk`, starts an encryption.
- `Nr`  in  4  Round count: 10, 12 or 14. Any other value runs as 10.
- `init`  in  128  Plaintext. Bits [127:120] are byte 0, i.e. s[0,0]; the state array is column-major.
- `w`  in  1920  Expanded key schedule. Round key r is `w[1919-128*r -: 128]`, r = 0..14, with the same byte order as `init`.
- `Encrypted_Msg`  out  128  Ciphertext register.
- `flag`  out  1  High when `Encrypted_Msg` holds a completed result.

## Operation
- Internal state:
  - 128-bit state register.
  - 4-bit round counter.
  - Latched `Nr`.
  - `busy` bit.
  - Registered copy of `cs`, used for edge detection.
- Start occurs when `cs`=1 and the registered `cs`=0. On start:
  - state ← `init` XOR round key 0.
  - round ← 1; latch `Nr`; busy ← 1; flag ← 0.
- Rounds 1..Nr-1 (one per clock): state ← MixColumns(ShiftRows(SubBytes(state))) XOR round key `round`; round increments.
- Round Nr (final round, no MixColumns):
  - `Encrypted_Msg` ← ShiftRows(SubBytes(state)) XOR round key Nr.
  - flag ← 1; busy ← 0.
- S-box: the standard 256-entry forward S-box, implemented combinationally as 16 parallel instances.
- MixColumns works over GF(2^8) with reduction polynomial 0x11B; xtime = (b<<1) XOR (b[7] ? 0x1B : 0).
- `flag` and `Encrypted_Msg` hold their values until the next start or reset.
- `init` and `Nr` are sampled only at start. `w` is read every round and must stay stable while busy.

## Timing
- Reset values: `Encrypted_Msg`=0, `flag`=0, busy=0, round=0, registered `cs`=0.
- If `cs` is high when reset deasserts, that counts as a rising edge: start occurs on the first clock after reset.
- Latency: `flag` rises on the Nr-th rising edge after the start edge, giving 11/13/15 edges in total including the start edge.
- `flag` drops on the start edge of the next encryption.
- A rising edge of `cs` while busy: see Configuration.
- Reset mid-operation aborts the encryption; all registers return to their reset values on that edge.
- `cs` held high after completion does not restart the engine; a low-then-high transition is required.

## Configuration
- Macro `AES_CIPHER_RESTART_EN`.
- Defined: a `cs` rising edge while busy aborts the current block and restarts with the current `init`/`Nr`. `flag` stays 0.
- Undefined: `cs` rising edges while busy are ignored; the running block completes normally.

## Test plan
- AES-128, FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, Nr=10, raise `cs` → ciphertext 3925841d02dc09fbdc118597196a0b32, with `flag` rising exactly 10 edges after the start edge.
- AES-128, App. C.1: key 000102…0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-192, App. C.2: key 000102…17, same pt, Nr=12 → dda97ca4864cdfe06eaf70a0ec0d7191, flag after 12 edges.
- AES-256, App. C.3: key 000102…1f, same pt, Nr=14 → 8ea2b7ca516745bfeafc49904b496089, flag after 14 edges.
- Reset and hold behaviour: assert `rst` at round 5 → `flag`=0 and `Encrypted_Msg`=0 on the next edge. Then hold `cs` high through reset release → encryption restarts and completes with the correct result. Keeping `cs` high afterwards causes no second run.
- Mid-run `cs` edge: toggle `cs` low→high at round 3 with a new `init`.
  - With `AES_CIPHER_RESTART_EN`: the result for the new `init` appears 10 edges after the toggle.
  - Without it: the original result appears on schedule.
